// File: rtl/modulo_exponent_pkg.sv
// Shared definitions for the modular exponentiation controller: operand width,
// exponent length mode codes and FSM state encodings.
package modulo_exponent_pkg;

   localparam int MAX_BITS = 256;
   localparam int MAX_REG  = MAX_BITS - 1;
   localparam int CNT_W    = 9;

   localparam logic [1:0] BITS32  = 2'd0;
   localparam logic [1:0] BITS64  = 2'd1;
   localparam logic [1:0] BITS128 = 2'd2;
   localparam logic [1:0] BITS256 = 2'd3;

   typedef enum logic [2:0] {
      EXP_IDLE      = 3'd0,
      EXP_MUL_ISSUE = 3'd1,
      EXP_MUL_WAIT  = 3'd2,
      EXP_SQR_ISSUE = 3'd3,
      EXP_SQR_WAIT  = 3'd4,
      EXP_DONE      = 3'd5
   } exp_state_e;

   // Mask with the low len bits set; len may be the full operand width.
   function automatic logic [MAX_BITS-1:0] len_mask(input logic [CNT_W-1:0] len);
      logic [MAX_BITS-1:0] mask;
      for (int i = 0; i < MAX_BITS; i++) begin
         mask[i] = (i < int'(len));
      end
      return mask;
   endfunction

endpackage

// File: rtl/modulo_exponent_exp_len_decode.sv
// Turns the 2-bit mode code into the exponent scan length and the mask that
// clears exponent bits beyond it.
module exp_len_decode
   import modulo_exponent_pkg::*;
(
   input  logic [1:0]          i_mode,
   output logic [CNT_W-1:0]    o_len,
   output logic [MAX_BITS-1:0] o_mask
);

   always_comb begin
      o_len = CNT_W'(32);
      unique case (i_mode)
         BITS32:  o_len = CNT_W'(32);
         BITS64:  o_len = CNT_W'(64);
         BITS128: o_len = CNT_W'(128);
         BITS256: o_len = CNT_W'(256);
         default: o_len = CNT_W'(32);
      endcase
   end

   assign o_mask = len_mask(o_len);

endmodule

// File: rtl/modulo_exponent.sv
// Right-to-left square-and-multiply controller; all products come from an
// external modular multiplier driven over a start/finished handshake.
module modulo_exponent
   import modulo_exponent_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [1:0]          i_mode,
   input  logic [MAX_BITS-1:0] i_n,
   input  logic [MAX_BITS-1:0] i_base,
   input  logic [MAX_BITS-1:0] i_exp,
   output logic [MAX_BITS-1:0] o_result,
   output logic                o_finished,
   output logic                o_busy,
   output logic                o_mul_start,
   output logic [MAX_BITS-1:0] o_mul_a,
   output logic [MAX_BITS-1:0] o_mul_b,
   output logic [MAX_BITS-1:0] o_mul_n,
   input  logic [MAX_BITS-1:0] i_mul_result,
   input  logic                i_mul_finished
);

   exp_state_e          state_q, state_d;
   logic [MAX_BITS-1:0] n_q, n_d;
   logic [MAX_BITS-1:0] e_q, e_d;
   logic [MAX_BITS-1:0] base_q, base_d;
   logic [MAX_BITS-1:0] res_q, res_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [MAX_BITS-1:0] result_q, result_d;
   logic                finished_q, finished_d;
   logic                busy_q, busy_d;
   logic                mul_start_q, mul_start_d;
   logic [MAX_BITS-1:0] mul_a_q, mul_a_d;
   logic [MAX_BITS-1:0] mul_b_q, mul_b_d;
   logic [MAX_BITS-1:0] mul_n_q, mul_n_d;

   logic [CNT_W-1:0]    dec_len;
   logic [MAX_BITS-1:0] dec_mask;
   logic [MAX_BITS-1:0] masked_exp;
   logic [MAX_BITS-1:0] e_shift;
   logic [CNT_W-1:0]    cnt_inc;
   logic                n_is_one;

   exp_len_decode u_len_decode (
      .i_mode (i_mode),
      .o_len  (dec_len),
      .o_mask (dec_mask)
   );

   assign masked_exp = i_exp & dec_mask;
   assign n_is_one   = (i_n == MAX_BITS'(1));
   assign e_shift    = e_q >> 1;
   assign cnt_inc    = bit_cnt_q + CNT_W'(1);

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      e_d         = e_q;
      base_d      = base_q;
      res_d       = res_q;
      len_d       = len_q;
      bit_cnt_d   = bit_cnt_q;
      result_d    = result_q;
      finished_d  = 1'b0;
      busy_d      = busy_q;
      mul_start_d = 1'b0;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_n_d     = mul_n_q;

      unique case (state_q)
         EXP_IDLE: begin
            busy_d = i_start;
            if (i_start) begin
               n_d       = i_n;
               len_d     = dec_len;
               e_d       = masked_exp;
               base_d    = i_base;
               res_d     = n_is_one ? '0 : MAX_BITS'(1);
               bit_cnt_d = '0;
               if (masked_exp == '0 || n_is_one) begin
                  state_d = EXP_DONE;
               end else if (masked_exp[0]) begin
                  state_d = EXP_MUL_ISSUE;
               end else begin
                  state_d = EXP_SQR_ISSUE;
               end
            end
         end
         EXP_MUL_ISSUE: begin
            mul_a_d     = res_q;
            mul_b_d     = base_q;
            mul_n_d     = n_q;
            mul_start_d = 1'b1;
            state_d     = EXP_MUL_WAIT;
         end
         // The square after the last multiply would never be used, so skip it.
         EXP_MUL_WAIT: begin
            if (i_mul_finished) begin
               res_d   = i_mul_result;
               state_d = (e_shift == '0) ? EXP_DONE : EXP_SQR_ISSUE;
            end
         end
         EXP_SQR_ISSUE: begin
            mul_a_d     = base_q;
            mul_b_d     = base_q;
            mul_n_d     = n_q;
            mul_start_d = 1'b1;
            state_d     = EXP_SQR_WAIT;
         end
         EXP_SQR_WAIT: begin
            if (i_mul_finished) begin
               base_d    = i_mul_result;
               e_d       = e_shift;
               bit_cnt_d = cnt_inc;
               if (e_shift == '0 || cnt_inc == len_q) begin
                  state_d = EXP_DONE;
               end else if (e_shift[0]) begin
                  state_d = EXP_MUL_ISSUE;
               end else begin
                  state_d = EXP_SQR_ISSUE;
               end
            end
         end
         EXP_DONE: begin
            result_d   = res_q;
            finished_d = 1'b1;
            state_d    = EXP_IDLE;
         end
         default: begin
            state_d = EXP_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= EXP_IDLE;
         n_q         <= '0;
         e_q         <= '0;
         base_q      <= '0;
         res_q       <= '0;
         len_q       <= '0;
         bit_cnt_q   <= '0;
         result_q    <= '0;
         finished_q  <= 1'b0;
         busy_q      <= 1'b0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_n_q     <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         e_q         <= e_d;
         base_q      <= base_d;
         res_q       <= res_d;
         len_q       <= len_d;
         bit_cnt_q   <= bit_cnt_d;
         result_q    <= result_d;
         finished_q  <= finished_d;
         busy_q      <= busy_d;
         mul_start_q <= mul_start_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_n_q     <= mul_n_d;
      end
   end

   assign o_result    = result_q;
   assign o_finished  = finished_q;
   assign o_busy      = busy_q;
   assign o_mul_start = mul_start_q;
   assign o_mul_a     = mul_a_q;
   assign o_mul_b     = mul_b_q;
   assign o_mul_n     = mul_n_q;

endmodule

// File: tb/tb_modulo_exponent.sv
// Directed bench for modulo_exponent with a fixed-latency behavioural
// modular multiplier standing in for the shared shift-add unit.
module tb_modulo_exponent;
   import modulo_exponent_pkg::*;

   localparam int T_MUL  = 3;
   localparam int BUDGET = 5000;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [1:0]          mode;
   logic [MAX_BITS-1:0] n_in, base_in, exp_in;
   logic [MAX_BITS-1:0] result;
   logic                finished, busy, mul_start;
   logic [MAX_BITS-1:0] mul_a, mul_b, mul_n;
   logic [MAX_BITS-1:0] mul_result;
   logic                mul_finished, mdl_fin, stray_fin;

   int checks = 0;
   int errors = 0;
   int start_count = 0;
   int overlap_count = 0;
   int unstable_count = 0;

   logic                pending;
   int                  cnt;
   logic [MAX_BITS-1:0] la, lb, ln;

   always #5 clk = ~clk;

   assign mul_finished = mdl_fin | stray_fin;

   modulo_exponent dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_start        (start),
      .i_mode         (mode),
      .i_n            (n_in),
      .i_base         (base_in),
      .i_exp          (exp_in),
      .o_result       (result),
      .o_finished     (finished),
      .o_busy         (busy),
      .o_mul_start    (mul_start),
      .o_mul_a        (mul_a),
      .o_mul_b        (mul_b),
      .o_mul_n        (mul_n),
      .i_mul_result   (mul_result),
      .i_mul_finished (mul_finished)
   );

   function automatic logic [MAX_BITS-1:0] mod_mul(input logic [MAX_BITS-1:0] a,
                                                   input logic [MAX_BITS-1:0] b,
                                                   input logic [MAX_BITS-1:0] m);
      logic [2*MAX_BITS-1:0] p;
      p = {{MAX_BITS{1'b0}}, a} * {{MAX_BITS{1'b0}}, b};
      return MAX_BITS'(p % {{MAX_BITS{1'b0}}, m});
   endfunction

   // Multiplier stand-in: counts starts, flags overlapping starts and operand changes.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         mdl_fin <= 1'b0;
         cnt     <= 0;
      end else begin
         mdl_fin <= 1'b0;
         if (mul_start) begin
            if (pending) overlap_count <= overlap_count + 1;
            start_count <= start_count + 1;
            pending <= 1'b1;
            cnt <= T_MUL;
            la <= mul_a;
            lb <= mul_b;
            ln <= mul_n;
         end else if (pending) begin
            if (mul_a !== la || mul_b !== lb || mul_n !== ln) unstable_count <= unstable_count + 1;
            if (cnt == 1) begin
               pending    <= 1'b0;
               mdl_fin    <= 1'b1;
               mul_result <= mod_mul(la, lb, ln);
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   task automatic run_op(input logic [1:0] m, input logic [MAX_BITS-1:0] n,
                         input logic [MAX_BITS-1:0] b, input logic [MAX_BITS-1:0] e,
                         output logic [MAX_BITS-1:0] res, output int cycles,
                         output int muls, output logic single, output logic busy_at_fin);
      int s0;
      logic done;
      @(negedge clk);
      mode = m; n_in = n; base_in = b; exp_in = e; start = 1'b1;
      s0 = start_count;
      cycles = 0;
      done = 1'b0;
      busy_at_fin = 1'b0;
      while (!done && cycles < BUDGET) begin
         @(posedge clk); #1;
         start = 1'b0;
         cycles++;
         if (finished) begin
            done = 1'b1;
            busy_at_fin = busy;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("[TB] FAIL timeout: o_finished never rose within %0d cycles", BUDGET);
      end
      res = result;
      muls = start_count - s0;
      @(posedge clk); #1;
      single = !finished;
   endtask

   task automatic test_reset();
      checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result got %0d expected 0", result); end
      checks++; if (finished !== 1'b0) begin errors++; $display("[TB] FAIL reset_finished got %b expected 0", finished); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
      checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_mul_start got %b expected 0", mul_start); end
      checks++; if (mul_a !== '0 || mul_b !== '0 || mul_n !== '0) begin
         errors++; $display("[TB] FAIL reset_operands got a=%0d b=%0d n=%0d expected 0", mul_a, mul_b, mul_n);
      end
   endtask

   task automatic test_basic();
      logic [MAX_BITS-1:0] r;
      int cyc, muls;
      logic single, bf;
      int u0, o0;
      u0 = unstable_count; o0 = overlap_count;
      run_op(BITS32, 256'd7, 256'd3, 256'd5, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd5) begin errors++; $display("[TB] FAIL pow_3_5_mod_7 got %0d expected 5", r); end
      checks++; if (muls != 4) begin errors++; $display("[TB] FAIL pow_3_5_muls got %0d expected 4", muls); end
      checks++; if (bf !== 1'b1) begin errors++; $display("[TB] FAIL busy_in_finish_cycle got %b expected 1", bf); end
      run_op(BITS32, 256'd1000, 256'd2, 256'd10, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd24) begin errors++; $display("[TB] FAIL pow_2_10_mod_1000 got %0d expected 24", r); end
      checks++; if (single !== 1'b1) begin errors++; $display("[TB] FAIL finished_single_pulse got %b expected 1", single); end
      checks++; if (muls != 5) begin errors++; $display("[TB] FAIL pow_2_10_muls got %0d expected 5", muls); end
      checks++; if (unstable_count != u0) begin errors++; $display("[TB] FAIL operand_stability got %0d changes expected 0", unstable_count - u0); end
      checks++; if (overlap_count != o0) begin errors++; $display("[TB] FAIL start_overlap got %0d expected 0", overlap_count - o0); end
   endtask

   task automatic test_trivial();
      logic [MAX_BITS-1:0] r;
      int cyc, muls;
      logic single, bf;
      run_op(BITS32, 256'd13, 256'd6, 256'd0, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd1) begin errors++; $display("[TB] FAIL exp_zero_result got %0d expected 1", r); end
      checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL exp_zero_latency got %0d expected 2", cyc); end
      checks++; if (muls != 0) begin errors++; $display("[TB] FAIL exp_zero_muls got %0d expected 0", muls); end
      run_op(BITS32, 256'd1, 256'd0, 256'd7, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd0) begin errors++; $display("[TB] FAIL n_one_result got %0d expected 0", r); end
      checks++; if (cyc != 2) begin errors++; $display("[TB] FAIL n_one_latency got %0d expected 2", cyc); end
      checks++; if (muls != 0) begin errors++; $display("[TB] FAIL n_one_muls got %0d expected 0", muls); end
   endtask

   task automatic test_modes();
      logic [MAX_BITS-1:0] r, e;
      int cyc, muls;
      logic single, bf;
      e = (256'd1 << 40) + 256'd3;
      run_op(BITS32, 256'd11, 256'd5, e, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd4) begin errors++; $display("[TB] FAIL mask32_result got %0d expected 4", r); end
      run_op(BITS64, 256'd11, 256'd5, e, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd9) begin errors++; $display("[TB] FAIL mode64_result got %0d expected 9", r); end
      e = (256'd1 << 100) + 256'd1;
      run_op(BITS64, 256'd11, 256'd2, e, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd2) begin errors++; $display("[TB] FAIL mask64_result got %0d expected 2", r); end
      run_op(BITS128, 256'd11, 256'd2, e, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd7) begin errors++; $display("[TB] FAIL mode128_result got %0d expected 7", r); end
      e = 256'd1 << 200;
      run_op(BITS128, 256'd7, 256'd3, e, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd1) begin errors++; $display("[TB] FAIL mask128_result got %0d expected 1", r); end
      run_op(BITS256, 256'd7, 256'd3, e, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd4) begin errors++; $display("[TB] FAIL mode256_result got %0d expected 4", r); end
   endtask

   task automatic test_back_to_back();
      int s0, cyc;
      logic done;
      @(negedge clk);
      mode = BITS32; n_in = 256'd7; base_in = 256'd3; exp_in = 256'd5; start = 1'b1;
      s0 = start_count;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid_run got %b expected 1", busy); end
      n_in = 256'd5; base_in = 256'd2; exp_in = 256'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0; done = 1'b0;
      while (!done && cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
         if (finished) done = 1'b1;
      end
      checks++; if (!done) begin errors++; $display("[TB] FAIL b2b_timeout got no finish expected finish"); end
      checks++; if (result !== 256'd5) begin errors++; $display("[TB] FAIL b2b_result got %0d expected 5", result); end
      checks++; if (start_count - s0 != 4) begin errors++; $display("[TB] FAIL b2b_muls got %0d expected 4", start_count - s0); end
      repeat (3) @(negedge clk);
      checks++; if (result !== 256'd5) begin errors++; $display("[TB] FAIL result_held got %0d expected 5", result); end
      checks++; if (busy !== 1'b0 || finished !== 1'b0) begin
         errors++; $display("[TB] FAIL idle_after_done got busy=%b fin=%b expected 0 0", busy, finished);
      end
   endtask

   task automatic test_reset_abort();
      logic [MAX_BITS-1:0] r;
      int s0, s1, cyc, muls;
      logic single, bf;
      @(negedge clk);
      mode = BITS32; n_in = 256'd497; base_in = 256'd4; exp_in = 256'd13; start = 1'b1;
      s0 = start_count;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (start_count - s0 < 2 && cyc < BUDGET) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (start_count - s0 != 2) begin errors++; $display("[TB] FAIL abort_reach_sqr got %0d starts expected 2", start_count - s0); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || finished !== 1'b0 || mul_start !== 1'b0 || result !== '0) begin
         errors++; $display("[TB] FAIL abort_outputs got busy=%b fin=%b start=%b res=%0d expected 0", busy, finished, mul_start, result);
      end
      checks++; if (mul_a !== '0 || mul_b !== '0 || mul_n !== '0) begin
         errors++; $display("[TB] FAIL abort_operands got a=%0d b=%0d n=%0d expected 0", mul_a, mul_b, mul_n);
      end
      @(negedge clk); rst_n = 1'b1;
      s1 = start_count;
      @(negedge clk); stray_fin = 1'b1;
      @(negedge clk); stray_fin = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0 || finished !== 1'b0 || result !== '0) begin
         errors++; $display("[TB] FAIL stray_finish got busy=%b fin=%b res=%0d expected 0", busy, finished, result);
      end
      checks++; if (start_count != s1) begin errors++; $display("[TB] FAIL stray_mul_start got %0d expected 0", start_count - s1); end
      run_op(BITS32, 256'd497, 256'd4, 256'd13, r, cyc, muls, single, bf);
      checks++; if (r !== 256'd445) begin errors++; $display("[TB] FAIL pow_4_13_mod_497 got %0d expected 445", r); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stray_fin = 1'b0;
      mode = BITS32; n_in = '0; base_in = '0; exp_in = '0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_trivial();
      test_modes();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
